// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO. The frame format (data width, parity,
// stop bits) is fixed at elaboration; queued frames go out back-to-back.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_n,
  input  logic                        i_Tx_DV,
  input  logic [DATA_BITS-1:0]        i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Done,
  output logic                        o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);
  localparam int unsigned STOP_W  = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [STOP_W-1:0]    stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;
  logic                 overflow_q;
  logic                 ready_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 full_c;
  logic                 empty_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 bit_end_c;
  logic                 frame_end_c;
  logic [DATA_BITS-1:0] head_c;
  logic                 head_par_c;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // never rescues a write into a full FIFO.
  always_comb begin
    full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    empty_c     = (count_q == '0);
    push_c      = i_Tx_DV & ~full_c;
    bit_end_c   = (timer_q == TIMER_W'(CLKS_PER_BIT - 1));
    frame_end_c = (state_q == S_STOP) & bit_end_c &
                  (stop_cnt_q == STOP_W'(STOP_BITS - 1));
    pop_c       = ~empty_c & ((state_q == S_IDLE) | frame_end_c);
    head_c      = mem_q[rd_ptr_q];
    head_par_c  = (PARITY == 1) ? ~^head_c : ^head_c;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= (count_d < CNT_W'(FIFO_DEPTH));
      overflow_q <= i_Tx_DV & full_c;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge i_Clock) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  // Frame sequencer. The line value for the next state is registered on the
  // same edge as the state change, so o_Tx_Serial tracks the state exactly.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          serial_q <= 1'b1;
          active_q <= 1'b0;
          timer_q  <= '0;
          if (pop_c) begin
            shift_q  <= head_c;
            parity_q <= head_par_c;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (bit_end_c) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end_c) begin
            timer_q <= '0;
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                serial_q <= parity_q;
                state_q  <= S_PARITY;
              end else begin
                serial_q   <= 1'b1;
                stop_cnt_q <= '0;
                state_q    <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              serial_q  <= shift_q[1];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end_c) begin
            timer_q    <= '0;
            serial_q   <= 1'b1;
            stop_cnt_q <= '0;
            state_q    <= S_STOP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end_c) begin
            timer_q <= '0;
            if (frame_end_c) begin
              done_q     <= 1'b1;
              stop_cnt_q <= '0;
              if (pop_c) begin
                shift_q  <= head_c;
                parity_q <= head_par_c;
                serial_q <= 1'b0;
                active_q <= 1'b1;
                state_q  <= S_START;
              end else begin
                serial_q <= 1'b1;
                active_q <= 1'b0;
                state_q  <= S_IDLE;
              end
            end else begin
              stop_cnt_q <= stop_cnt_q + STOP_W'(1);
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        default: begin
          serial_q <= 1'b1;
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Tx_Ready   = ready_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Done    = done_q;
  assign o_Overflow   = overflow_q;
  assign o_Fifo_Count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame-format variants, stimulus queues expected
// frames, a per-unit line monitor pops them and checks every sampled cycle.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 10;
  localparam int unsigned NU  = 4;

  function automatic int unsigned cfg_db(input int unsigned g);
    return (g == 3) ? 7 : 8;
  endfunction
  function automatic int unsigned cfg_par(input int unsigned g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction
  function automatic int unsigned cfg_sb(input int unsigned g);
    return (g == 3) ? 2 : 1;
  endfunction

  typedef struct packed {
    logic [8:0]         data;
    logic               par;
    logic signed [15:0] gap;
  } exp_t;

  logic            clk;
  logic [NU-1:0]   rst_n;
  logic [NU-1:0]   dv;
  logic [8:0]      byte_s [NU];
  wire  [NU-1:0]   ser, act, dn, ovf, rdy;
  wire  [2:0]      cnt [NU];

  exp_t exp_q [NU][$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int g, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s unit%0d: got %0h expected %0h at %0t", name, g, got, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [8:0] d, input logic p, input int gap);
    exp_t it;
    it.data = d;
    it.par  = p;
    it.gap  = 16'(gap);
    exp_q[g].push_back(it);
  endtask

  task automatic drive(input int g, input logic [8:0] d);
    @(negedge clk);
    dv[g]     = 1'b1;
    byte_s[g] = d;
  endtask

  task automatic idle(input int g);
    @(negedge clk);
    dv[g] = 1'b0;
  endtask

  task automatic wr(input int g, input logic [8:0] d);
    drive(g, d);
    idle(g);
  endtask

  for (genvar g = 0; g < NU; g++) begin : gen_u
    localparam int unsigned DB  = cfg_db(g);
    localparam int unsigned PAR = cfg_par(g);
    localparam int unsigned SB  = cfg_sb(g);
    localparam int unsigned NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int unsigned F   = CPB * NB;

    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY      (PAR),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n[g]),
      .i_Tx_DV     (dv[g]),
      .i_Tx_Byte   (byte_s[g][DB-1:0]),
      .o_Tx_Ready  (rdy[g]),
      .o_Tx_Active (act[g]),
      .o_Tx_Serial (ser[g]),
      .o_Tx_Done   (dn[g]),
      .o_Overflow  (ovf[g]),
      .o_Fifo_Count(cnt[g])
    );

    // Line monitor: one frame per expected entry, sampled every falling edge.
    initial begin : mon
      exp_t        it;
      logic [12:0] got_w, exp_w;
      int          gap, bad_bits, bad_act, bad_done;
      bit          aborted;
      gap = -1;
      @(negedge clk);
      forever begin
        while (!(rst_n[g] === 1'b1 && ser[g] === 1'b0)) begin
          if (rst_n[g] !== 1'b1) begin
            exp_q[g].delete();
            gap = -1;
          end else if (gap >= 0) begin
            gap++;
          end
          @(negedge clk);
        end
        chk("frame_expected", g, 32'(exp_q[g].size() != 0), 32'd1);
        if (exp_q[g].size() != 0) begin
          it = exp_q[g].pop_front();
        end else begin
          it     = '0;
          it.gap = -16'sd1;
        end
        if (it.gap >= 0) chk("gap", g, 32'(gap), 32'(it.gap));
        exp_w    = '1;
        exp_w[0] = 1'b0;
        for (int i = 0; i < int'(DB); i++) exp_w[1+i] = it.data[i];
        if (PAR != 0) exp_w[1+DB] = it.par;
        got_w    = '1;
        bad_bits = 0;
        bad_act  = 0;
        bad_done = 0;
        aborted  = 1'b0;
        for (int c = 0; c < int'(F); c++) begin
          if (rst_n[g] !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (ser[g] !== exp_w[c / CPB]) bad_bits++;
          if (c % CPB == CPB / 2) got_w[c / CPB] = ser[g];
          if (act[g] !== 1'b1) bad_act++;
          if (c > 0 && dn[g] !== 1'b0) bad_done++;
          @(negedge clk);
        end
        if (rst_n[g] !== 1'b1) aborted = 1'b1;
        if (aborted) begin
          exp_q[g].delete();
          gap = -1;
        end else begin
          chk("frame_bits", g, 32'(got_w), 32'(exp_w));
          chk("bit_timing", g, 32'(bad_bits), 32'd0);
          chk("active_in_frame", g, 32'(bad_act), 32'd0);
          chk("done_early", g, 32'(bad_done), 32'd0);
          chk("done_pulse", g, 32'(dn[g]), 32'd1);
          chk("active_at_done", g, 32'(act[g]), 32'(ser[g] === 1'b0));
          gap = 0;
        end
      end
    end
  end

  initial begin : stim
    int bad_done, bad_ser;
    rst_n = '0;
    dv    = '0;
    for (int g = 0; g < int'(NU); g++) byte_s[g] = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    for (int g = 0; g < int'(NU); g++) begin
      chk("rst_serial", g, 32'(ser[g]), 32'd1);
      chk("rst_ready", g, 32'(rdy[g]), 32'd1);
      chk("rst_active", g, 32'(act[g]), 32'd0);
      chk("rst_done", g, 32'(dn[g]), 32'd0);
      chk("rst_overflow", g, 32'(ovf[g]), 32'd0);
      chk("rst_count", g, 32'(cnt[g]), 32'd0);
    end

    // Single 0xA5 frame: count then pop latency.
    push(0, 9'h0A5, 1'b0, -1);
    wr(0, 9'h0A5);
    chk("wr_count", 0, 32'(cnt[0]), 32'd1);
    chk("wr_serial_idle", 0, 32'(ser[0]), 32'd1);
    chk("wr_active_low", 0, 32'(act[0]), 32'd0);
    @(negedge clk);
    chk("pop_count", 0, 32'(cnt[0]), 32'd0);
    chk("pop_start_bit", 0, 32'(ser[0]), 32'd0);
    chk("pop_active", 0, 32'(act[0]), 32'd1);
    repeat (110) @(negedge clk);

    // Parity variants: even 0xA5 -> 0, odd 0xA5 -> 1, odd 0x07 -> 0.
    push(1, 9'h0A5, 1'b0, -1);
    wr(1, 9'h0A5);
    push(2, 9'h0A5, 1'b1, -1);
    push(2, 9'h007, 1'b0, 0);
    drive(2, 9'h0A5);
    drive(2, 9'h007);
    idle(2);
    repeat (240) @(negedge clk);

    // 7 data bits, 2 stop bits.
    push(3, 9'h055, 1'b0, -1);
    wr(3, 9'h055);
    repeat (110) @(negedge clk);

    // Six consecutive writes into a depth-4 FIFO.
    push(0, 9'h001, 1'b0, -1);
    for (int k = 2; k <= 5; k++) push(0, 9'(k), 1'b0, 0);
    for (int k = 1; k <= 6; k++) drive(0, 9'(k));
    idle(0);
    chk("ovf_pulse", 0, 32'(ovf[0]), 32'd1);
    chk("full_count", 0, 32'(cnt[0]), 32'd4);
    chk("full_not_ready", 0, 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("ovf_one_cycle", 0, 32'(ovf[0]), 32'd0);
    chk("full_count_hold", 0, 32'(cnt[0]), 32'd4);
    repeat (94) @(negedge clk);
    chk("ready_low_till_done", 0, 32'(rdy[0]), 32'd0);
    chk("count_before_done", 0, 32'(cnt[0]), 32'd4);
    @(negedge clk);
    chk("ready_after_pop", 0, 32'(rdy[0]), 32'd1);
    chk("count_after_pop", 0, 32'(cnt[0]), 32'd3);
    chk("first_done", 0, 32'(dn[0]), 32'd1);
    repeat (420) @(negedge clk);

    // Write sampled on the edge that raises o_Tx_Done for the last frame.
    push(0, 9'h03C, 1'b0, -1);
    push(0, 9'h0C3, 1'b0, 1);
    wr(0, 9'h03C);
    repeat (99) @(negedge clk);
    drive(0, 9'h0C3);
    idle(0);
    chk("late_wr_done", 0, 32'(dn[0]), 32'd1);
    chk("late_wr_idle_line", 0, 32'(ser[0]), 32'd1);
    chk("late_wr_count", 0, 32'(cnt[0]), 32'd1);
    @(negedge clk);
    chk("late_wr_start", 0, 32'(ser[0]), 32'd0);
    chk("late_wr_count_pop", 0, 32'(cnt[0]), 32'd0);
    repeat (110) @(negedge clk);

    // Reset during data bit 3 of 0xA5 with two more bytes queued.
    push(0, 9'h0A5, 1'b0, -1);
    push(0, 9'h011, 1'b0, 0);
    push(0, 9'h022, 1'b0, 0);
    wr(0, 9'h0A5);
    wr(0, 9'h011);
    wr(0, 9'h022);
    chk("queued_count", 0, 32'(cnt[0]), 32'd2);
    repeat (41) @(negedge clk);
    chk("bit3_low", 0, 32'(ser[0]), 32'd0);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("async_serial_high", 0, 32'(ser[0]), 32'd1);
    chk("async_count_clear", 0, 32'(cnt[0]), 32'd0);
    chk("async_active_clear", 0, 32'(act[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n[0] = 1'b1;
    bad_done = 0;
    bad_ser  = 0;
    repeat (150) begin
      @(negedge clk);
      if (dn[0] !== 1'b0) bad_done++;
      if (ser[0] !== 1'b1) bad_ser++;
    end
    chk("post_rst_no_done", 0, 32'(bad_done), 32'd0);
    chk("post_rst_line_idle", 0, 32'(bad_ser), 32'd0);
    chk("post_rst_count", 0, 32'(cnt[0]), 32'd0);

    for (int g = 0; g < int'(NU); g++) begin
      chk("queue_drained", g, 32'(exp_q[g].size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
